// File: rtl/req_responder_pkg.sv
// req_responder_pkg: channel codes and FSM states shared with the memory controller
package req_responder_pkg;
  typedef enum logic [1:0] {
    CH_NONE = 2'b00,
    CH_WGHT = 2'b01,
    CH_MTRX = 2'b10,
    CH_INST = 2'b11
  } chan_e;
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    RESP  = 2'b10
  } state_e;
endpackage

// File: rtl/req_responder_byte_fifo.sv
// byte_fifo: DEPTH-entry staging FIFO with occupancy count
module byte_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          din,
  output logic [DATA_W-1:0]          dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic wr, rd;
  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign wr    = push && !full;
  assign rd    = pop && !empty;
  assign dout  = mem[rd_ptr];
  // pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= rd ? rd_ptr + 1'b1 : rd_ptr;
      count  <= count + (AW+1)'(wr) - (AW+1)'(rd);
    end
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= din;
endmodule

// File: rtl/req_responder.sv
// req_responder: stages host bytes in three channel FIFOs and returns them on request
module req_responder
  import req_responder_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             load_valid,
  input  logic [1:0]                       load_sel,
  input  logic [DATA_W-1:0]                load_data,
  output logic                             load_ready,
  input  logic [1:0]                       req_type,
  input  logic                             req_valid,
  output logic                             rpi_ready,
  output logic [DATA_W-1:0]                rpi_data,
  output logic                             err,
  output logic [3*($clog2(DEPTH)+1)-1:0]   level
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [3:0] full, empty;
  logic [3:1] push, pop;
  logic [DATA_W-1:0] dout [4];
  logic [CW-1:0] cnt [1:3];
  state_e state;
  chan_e cap;
  // index 0 is the reserved code: never ready, never poppable
  assign full[0]    = 1'b1;
  assign empty[0]   = 1'b1;
  assign dout[0]    = '0;
  assign load_ready = load_sel != CH_NONE && !full[load_sel];
  for (genvar c = 1; c < 4; c++) begin : g_ch
    assign push[c] = load_valid && load_ready && load_sel == 2'(c);
    assign pop[c]  = state == FETCH && cap == chan_e'(c) && !empty[c];
    byte_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[c]),
      .pop   (pop[c]),
      .din   (load_data),
      .dout  (dout[c]),
      .full  (full[c]),
      .empty (empty[c]),
      .count (cnt[c])
    );
  end
  assign level = {cnt[3], cnt[2], cnt[1]};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      cap       <= CH_NONE;
      rpi_ready <= 1'b0;
      rpi_data  <= '0;
      err       <= 1'b0;
    end else begin
      rpi_ready <= 1'b0;
      err       <= 1'b0;
      case (state)
        IDLE:
          if (req_valid) begin
            if (req_type == CH_NONE) err <= 1'b1;
            else begin
              cap   <= chan_e'(req_type);
              state <= FETCH;
            end
          end
        FETCH:
          if (!empty[cap]) begin
            rpi_data  <= dout[cap];
            rpi_ready <= 1'b1;
            state     <= RESP;
          end else if (!req_valid) state <= IDLE;
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_req_responder.sv
// tb_req_responder: randomized scoreboard bench with queue-based channel model
module tb_req_responder;
  localparam int DEPTH = 8;
  localparam int DW    = 8;
  logic clk = 1'b0, rst_n = 1'b1;
  logic load_valid = 1'b0, req_valid = 1'b0;
  logic [1:0] load_sel = '0, req_type = '0;
  logic [DW-1:0] load_data = '0;
  logic load_ready, rpi_ready, err;
  logic [DW-1:0] rpi_data;
  logic [11:0] level;

  req_responder #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_sel(load_sel),
    .load_data(load_data), .load_ready(load_ready), .req_type(req_type),
    .req_valid(req_valid), .rpi_ready(rpi_ready), .rpi_data(rpi_data),
    .err(err), .level(level)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [DW-1:0] mq [4][$];
  logic [DW-1:0] exp_q [$];
  int err_exp = 0;
  logic [DW-1:0] last_data = '0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] exp_level();
    return {4'(mq[3].size()), 4'(mq[2].size()), 4'(mq[1].size())};
  endfunction

  // monitor: every returned byte must match the oldest expected one
  always @(negedge clk) begin
    if (rpi_ready) begin
      if (exp_q.size() == 0) chk("unexpected_rpi_ready", 32'(rpi_ready), 0);
      else chk("rpi_data", 32'(rpi_data), 32'(exp_q.pop_front()));
      last_data = rpi_data;
    end else if (rst_n) chk("rpi_data_hold", 32'(rpi_data), 32'(last_data));
    else last_data = '0;
    if (err) begin
      if (err_exp == 0) chk("unexpected_err", 32'(err), 0);
      else err_exp--;
    end
  end

  task automatic load(input logic [1:0] s, input logic [DW-1:0] d);
    logic rdy;
    @(negedge clk);
    load_valid = 1'b1; load_sel = s; load_data = d;
    #1;
    rdy = s != 2'b00 && mq[s].size() < DEPTH;
    chk("load_ready", 32'(load_ready), 32'(rdy));
    if (rdy) mq[s].push_back(d);
    @(posedge clk);
    #1 load_valid = 1'b0;
  endtask

  task automatic request(input logic [1:0] t, input int hold);
    @(negedge clk);
    req_valid = 1'b1; req_type = t;
    if (t == 2'b00) begin
      err_exp++;
      @(negedge clk);
      chk("err_pulse", 32'(err), 1);
      req_valid = 1'b0;
      @(negedge clk);
      chk("err_single", 32'(err), 0);
    end else if (mq[t].size() > 0) begin
      exp_q.push_back(mq[t].pop_front());
      @(negedge clk);
      chk("latency_early", 32'(rpi_ready), 0);
      req_type = 2'($urandom);
      @(negedge clk);
      chk("latency_2", 32'(rpi_ready), 1);
      req_valid = 1'b0;
      @(negedge clk);
    end else begin
      repeat (hold) @(negedge clk);
      req_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("abort_level", 32'(level), 32'(exp_level()));
    end
  endtask

  task automatic same_cycle(input logic [DW-1:0] d);
    logic rdy;
    @(negedge clk);
    req_valid = 1'b1; req_type = 2'b01;
    exp_q.push_back(mq[1].pop_front());
    @(negedge clk);
    rdy = mq[1].size() + 1 < DEPTH;
    load_valid = 1'b1; load_sel = 2'b01; load_data = d;
    #1 chk("pop_load_ready", 32'(load_ready), 32'(rdy));
    if (rdy) mq[1].push_back(d);
    @(negedge clk);
    load_valid = 1'b0; req_valid = 1'b0;
    chk("pop_pulse", 32'(rpi_ready), 1);
    chk("pop_level", 32'(level), 32'(exp_level()));
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rpi_ready", 32'(rpi_ready), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_rpi_data", 32'(rpi_data), 0);
    chk("rst_level", 32'(level), 0);

    // held request drains two bytes three cycles apart, then waits
    load(2'b01, 8'hA5);
    load(2'b01, 8'h3C);
    @(negedge clk);
    req_valid = 1'b1; req_type = 2'b01;
    exp_q.push_back(mq[1].pop_front());
    exp_q.push_back(mq[1].pop_front());
    repeat (2) @(negedge clk);
    chk("held_pulse1", 32'(rpi_ready), 1);
    repeat (3) @(negedge clk);
    chk("held_pulse2", 32'(rpi_ready), 1);
    repeat (6) @(negedge clk);
    chk("fetch_wait", 32'(rpi_ready), 0);
    req_valid = 1'b0;
    @(negedge clk);

    request(2'b00, 1);
    request(2'b10, 4);
    load(2'b10, 8'h5E);
    repeat (3) @(negedge clk);
    chk("post_abort_level", 32'(level), 32'(exp_level()));
    request(2'b10, 1);

    // offset inst pointers so the full fill crosses the wrap point
    for (int i = 0; i < 3; i++) load(2'b11, 8'($urandom));
    for (int i = 0; i < 3; i++) request(2'b11, 1);
    for (int i = 0; i < DEPTH; i++) load(2'b11, 8'(i));
    load(2'b11, 8'h08);
    chk("inst_full_level", 32'(level[11:8]), DEPTH);
    for (int i = 0; i < DEPTH; i++) request(2'b11, 1);

    for (int i = 0; i < 3; i++) load(2'b01, 8'($urandom));
    same_cycle(8'h77);
    while (mq[1].size() < DEPTH) load(2'b01, 8'($urandom));
    same_cycle(8'h88);
    while (mq[1].size() > 0) request(2'b01, 1);

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 2) != 0) load(2'($urandom), 8'($urandom));
      else request(2'($urandom), $urandom_range(1, 4));
      @(negedge clk);
      chk("rand_level", 32'(level), 32'(exp_level()));
    end

    // reset during RESP kills the pulse and empties every buffer
    load(2'b01, 8'h55);
    load(2'b11, 8'h66);
    @(negedge clk);
    req_valid = 1'b1; req_type = 2'b01;
    exp_q.push_back(mq[1].pop_front());
    repeat (2) @(negedge clk);
    chk("resp_before_rst", 32'(rpi_ready), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_ready", 32'(rpi_ready), 0);
    chk("rst_async_level", 32'(level), 0);
    chk("rst_async_data", 32'(rpi_data), 0);
    for (int c = 0; c < 4; c++) mq[c].delete();
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("no_pulse_after_rst", 32'(rpi_ready), 0);

    // reset during FETCH discards the pending pop
    load(2'b10, 8'h9A);
    @(negedge clk);
    req_valid = 1'b1; req_type = 2'b10;
    @(negedge clk);
    #1 rst_n = 1'b0;
    for (int c = 0; c < 4; c++) mq[c].delete();
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("fetch_rst_level", 32'(level), 0);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("err_all_seen", 32'(err_exp), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
